// File: rtl/alu_ex_stage.sv
// alu_ex_stage: single-cycle integer ALU execute stage with a registered
// result and a one-entry skid buffer, so in_ready depends only on state.
module alu_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      in_rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic [4:0]      out_rd_addr,
  output logic            out_illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t          state;
  logic [XLEN-1:0] res, skid_rd;
  logic [4:0]      skid_addr;
  logic            ill, skid_ill;
  logic [4:0]      shamt;
  logic            accept, consume;
  assign shamt     = rs2[4:0];
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  always_comb begin
    res = '0;
    ill = 1'b0;
    case (in_op)
      4'b0000: res = rs1 + rs2;
      4'b1000: res = rs1 - rs2;
      4'b0001: res = rs1 << shamt;
      4'b0010: res = XLEN'($signed(rs1) < $signed(rs2));
      4'b0011: res = XLEN'(rs1 < rs2);
      4'b0100: res = rs1 ^ rs2;
      4'b0101: res = rs1 >> shamt;
      4'b1101: res = $unsigned($signed(rs1) >>> shamt);
      4'b0110: res = rs1 | rs2;
      4'b0111: res = rs1 & rs2;
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      rd          <= '0;
      out_rd_addr <= '0;
      out_illegal <= 1'b0;
      skid_rd     <= '0;
      skid_addr   <= '0;
      skid_ill    <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          rd          <= res;
          out_rd_addr <= in_rd_addr;
          out_illegal <= ill;
          state       <= ONE;
        end
        ONE: if (accept && consume) begin
          rd          <= res;
          out_rd_addr <= in_rd_addr;
          out_illegal <= ill;
        end else if (accept) begin
          skid_rd     <= res;
          skid_addr   <= in_rd_addr;
          skid_ill    <= ill;
          state       <= FULL;
        end else if (consume) begin
          state       <= EMPTY;
        end
        FULL: if (consume) begin
          rd          <= skid_rd;
          out_rd_addr <= skid_addr;
          out_illegal <= skid_ill;
          state       <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: directed vectors with hand-computed results for alu_ex_stage.
module tb_alu_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rd;
  logic [4:0]  out_rd_addr;
  logic        out_illegal;
  int          checks = 0, failures = 0;
  logic [4:0]  tag = 5'd1;

  alu_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .rs1(rs1), .rs2(rs2), .in_rd_addr(in_rd_addr),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd),
    .out_rd_addr(out_rd_addr), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    in_valid = 1'b1; in_op = op; rs1 = a; rs2 = b; in_rd_addr = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_ill);
    drive(op, a, b, tag);
    tick();
    in_valid = 1'b0;
    chk({name, "_rd"}, rd, exp);
    chk({name, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    chk({name, "_tag"}, {27'd0, out_rd_addr}, {27'd0, tag});
    chk({name, "_vld"}, {31'd0, out_valid}, 32'd1);
    tag = tag + 5'd1;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_rd", rd, 32'd0);
    chk("rst_tag", {27'd0, out_rd_addr}, 32'd0);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    op_chk("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
    op_chk("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    op_chk("sub_wrap", 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    op_chk("sll", 4'b0001, 32'd1, 32'h21, 32'd2, 1'b0);
    op_chk("slt_neg", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    op_chk("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    op_chk("sltu_1_2", 4'b0011, 32'd1, 32'd2, 32'd1, 1'b0);
    op_chk("sltu_2_1", 4'b0011, 32'd2, 32'd1, 32'd0, 1'b0);
    op_chk("sltu_eq", 4'b0011, 32'd1, 32'd1, 32'd0, 1'b0);
    op_chk("sltu_ff_fe", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b0);
    op_chk("xor", 4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    op_chk("srl", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    op_chk("sra", 4'b1101, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0);
    op_chk("or", 4'b0110, 32'hF0, 32'h0F, 32'hFF, 1'b0);
    op_chk("and", 4'b0111, 32'hF0, 32'h3C, 32'h30, 1'b0);
    op_chk("illegal", 4'b1001, 32'd5, 32'd3, 32'd0, 1'b1);
    op_chk("legal_after", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    // back-pressure fills main then skid
    out_ready = 1'b0;
    drive(4'b0000, 32'd1, 32'd1, 5'd3);
    tick();
    chk("bp1_rd", rd, 32'd2);
    chk("bp1_ready", {31'd0, in_ready}, 32'd1);
    drive(4'b0000, 32'd2, 32'd2, 5'd4);
    tick();
    chk("bp2_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2_rd", rd, 32'd2);
    chk("bp2_tag", {27'd0, out_rd_addr}, 32'd3);
    drive(4'b0000, 32'd9, 32'd9, 5'd9);
    tick();
    chk("bp_ignore_rd", rd, 32'd2);
    chk("bp_ignore_tag", {27'd0, out_rd_addr}, 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_drain_rd", rd, 32'd4);
    chk("bp_drain_tag", {27'd0, out_rd_addr}, 32'd4);
    chk("bp_drain_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_drain_vld", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    // streaming: one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(4'b0000, 32'(i), 32'd100, 5'(i + 10));
      tick();
      chk("stream_rd", rd, 32'(i + 100));
      chk("stream_tag", {27'd0, out_rd_addr}, 32'(i + 10));
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_vld", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", {31'd0, out_valid}, 32'd0);
    // reset while FULL
    out_ready = 1'b0;
    drive(4'b0000, 32'd10, 32'd10, 5'd5);
    tick();
    drive(4'b0000, 32'd20, 32'd20, 5'd6);
    tick();
    in_valid = 1'b0;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_rd", rd, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_tag", {27'd0, out_rd_addr}, 32'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
    drive(4'b0000, 32'd3, 32'd3, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("post_rst_rd", rd, 32'd6);
    chk("post_rst_tag", {27'd0, out_rd_addr}, 32'd7);
    tick();
    chk("post_rst_nostale", {31'd0, out_valid}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
